seq_detect_fsm: RTL and testbench
=================================

# seq_detect_fsm

Parametrised Mealy sequence detector: recognises a runtime-loadable pattern of `LEN` symbols, each `SYM_W` bits wide, in an enabled symbol stream. It generalises the fixed 4-state, 2-bit-input Mealy lab FSM in four ways:
- any symbol width and pattern length;
- overlapping or non-overlapping detection, selected at run time;
- KMP-style fallback on a mismatch;
- a saturating match counter.

It sits in the FSM labs as a drop-in stream monitor driven by the same `en` strobe style.

## Interface
Parameters:
- `SYM_W`, default 2: symbol width in bits, ≥1.
- `LEN`, default 4: pattern length in symbols, ≥2.
- `CNT_W`, default 8: match counter width, ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  symbol strobe; `in_sym` is consumed only when high.
- `in_sym`  in  SYM_W  current symbol.
- `overlap`  in  1  1 = overlapping matches, 0 = non-overlapping; sampled on every consumed symbol.
- `cfg_load`  in  1  load a new pattern.
- `cfg_pattern`  in  LEN*SYM_W  pattern; symbol i is `cfg_pattern[i*SYM_W +: SYM_W]`, and symbol 0 is the first expected.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `match`  out  1  Mealy output: combinational, high in the cycle the final pattern symbol is consumed.
- `state`  out  $clog2(LEN)  current matched-prefix length, 0..LEN-1.
- `match_cnt`  out  CNT_W  saturating count of matches.

## Operation
- **Registers:** pattern `P[0..LEN-1]`, state `s`, `match_cnt`. There is no symbol history register; the fallback is computed from `P` and `s` only.
- **Reset** (`rst_n` low, asynchronous): `P` = 0, `s` = 0, `match_cnt` = 0. `match` = 0 while in reset.
- **Priority per cycle:** `cfg_load` > `en`.
  - `cfg_load`=1: `P` ← `cfg_pattern`, `s` ← 0. `match` is forced to 0 and `in_sym` is ignored, even if `en`=1.
  - `en`=0 and `cfg_load`=0: `s` holds and `match` = 0.
- **Consumed symbol** x (`en`=1, `cfg_load`=0):
  - Define `ext(k, x)` = the largest j in 1..k+1 such that `P[0..j-2]` == `P[k-j+1..k-1]` and `P[j-1]` == x. It is 0 if no such j exists.
  - Let n = `ext(s, x)`.
  - If n < LEN: `s` ← n, `match` = 0.
  - If n == LEN: `match` = 1.
    - If `overlap`=1, `s` ← `B`, where `B` is the longest proper border of `P`: the largest b < LEN with `P[0..b-1]` == `P[LEN-b..LEN-1]`, possibly 0.
    - If `overlap`=0, `s` ← 0.
- **Counter:**
  - `cnt_clr`=1: `match_cnt` ← `match` ? 1 : 0. Clear and increment in the same cycle yields 1.
  - Otherwise, if `match`=1 and `match_cnt` is not all-ones: increment.
  - At all-ones the counter stays at all-ones.
  - `cnt_clr` is independent of `en` and `cfg_load`.
- `match` depends combinationally on `in_sym`, `en`, `cfg_load`, `s` and `P` only; there is no path from `overlap` or `cnt_clr`.

## Timing
- `match` has zero latency: it is valid in the same cycle as the final symbol. The `state` and `match_cnt` updates are visible after the next rising edge.
- **Pattern load:** a new pattern applies from the cycle after `cfg_load`. A load during a partial match discards that partial match.
- **Async reset mid-stream:** all outputs clear immediately. The first symbol consumed after `rst_n` rises is compared against `P[0]` of the zero pattern, until a pattern is loaded.
- **Pipeline behaviour:** there are no stalls, and back-to-back symbols are accepted every cycle.
- **Match spacing:** with `overlap`=1, consecutive matches can occur as little as LEN-B consumed symbols apart. With `overlap`=0, matches are at least LEN consumed symbols apart.

## Test plan
All scenarios use SYM_W=2, LEN=4, CNT_W=8 unless stated otherwise.

1. **Overlap on:** load P=2,1,2,1 (`cfg_pattern`=8'b01_10_01_10), `overlap`=1. Stream 2,1,2,1,2,1 with `en`=1 → `match` high on the 4th and 6th symbols; `state` sequence 1,2,3,2,3,2; `match_cnt`=2.
2. **Overlap off:** same pattern and stream, `overlap`=0 → `match` only on the 4th symbol; `state` after the 4th = 0, final `state`=2; `match_cnt`=1.
3. **Fallback:** P=1,1,2,3. Stream 1,1,1,2,3 → `state` 1,2,2,3, then `match` on the 5th symbol. Stream 1,1,3 → `state` returns to 0.
4. **Enable gaps and load priority:** stream 2,1 for P=2,1,2,1 with `en` low for 3 cycles between symbols → `state` holds through the gap and `match` stays 0. Then `cfg_load` with `en`=1 and `in_sym` completing the pattern → `match`=0 and `state`=0.
5. **Counter corners:** CNT_W=2, five overlapping matches → `match_cnt` saturates at 3. `cnt_clr` in the same cycle as `match` → `match_cnt`=1.
6. **Async reset:** assert `rst_n` low mid-stream at `state`=3, off a clock edge → `state`=0, `match_cnt`=0 and `match`=0 immediately. The old pattern is gone: `P`=0, so an input of 0,0,0,0 matches.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// Parametrised Mealy sequence detector with runtime-loadable pattern, KMP-style
// fallback, selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_fsm #(
    parameter int SYM_W = 2,
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [SYM_W-1:0]         in_sym,
    input  logic                     overlap,
    input  logic                     cfg_load,
    input  logic [LEN*SYM_W-1:0]     cfg_pattern,
    input  logic                     cnt_clr,
    output logic                     match,
    output logic [$clog2(LEN)-1:0]   state,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int SW = $clog2(LEN);
    localparam int NW = $clog2(LEN + 1);

    logic [SYM_W-1:0] pat [LEN];
    logic [SW-1:0]    s;
    logic [NW-1:0]    ext_tab [LEN];
    logic [NW-1:0]    border;
    logic [NW-1:0]    n;
    logic             ok;

    // ext(k, x) for every possible state k, built from the stored pattern only;
    // ascending j means the last hit is the longest extendable prefix.
    always_comb begin
        ok     = 1'b0;
        border = '0;
        for (int k = 0; k < LEN; k++) begin
            ext_tab[k] = '0;
            for (int j = 1; j <= k + 1; j++) begin
                ok = (pat[j-1] == in_sym);
                for (int i = 0; i < j - 1; i++) begin
                    if (pat[i] != pat[k-j+1+i]) ok = 1'b0;
                end
                if (ok) ext_tab[k] = NW'(j);
            end
        end
        for (int b = 1; b < LEN; b++) begin
            ok = 1'b1;
            for (int i = 0; i < b; i++) begin
                if (pat[i] != pat[LEN-b+i]) ok = 1'b0;
            end
            if (ok) border = NW'(b);
        end
    end

    always_comb begin
        n     = ext_tab[s];
        match = rst_n && en && !cfg_load && (n == NW'(LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) pat[i] <= '0;
            s         <= '0;
            match_cnt <= '0;
        end else begin
            if (cfg_load) begin
                for (int i = 0; i < LEN; i++) pat[i] <= cfg_pattern[i*SYM_W +: SYM_W];
                s <= '0;
            end else if (en) begin
                if (match) s <= overlap ? border[SW-1:0] : '0;
                else       s <= n[SW-1:0];
            end
            // Clear wins over the old value but still counts a match in the same cycle.
            if (cnt_clr)                   match_cnt <= match ? CNT_W'(1) : '0;
            else if (match && !(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    assign state = s;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: a default-width instance plus a CNT_W=2
// instance on the same stimulus for counter saturation.
module tb_seq_detect_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] in_sym;
    logic       overlap;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic       cnt_clr;

    logic       match;
    logic [1:0] state;
    logic [7:0] match_cnt;
    logic       match_s;
    logic [1:0] state_s;
    logic [1:0] match_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_fsm #(.SYM_W(2), .LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_sym(in_sym), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
        .match(match), .state(state), .match_cnt(match_cnt)
    );

    seq_detect_fsm #(.SYM_W(2), .LEN(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .en(en), .in_sym(in_sym), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
        .match(match_s), .state(state_s), .match_cnt(match_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One consumed symbol: match sampled mid-cycle, state after the edge.
    task automatic send(input logic [1:0] x, input logic clr, input logic exp_m,
                        input int exp_s, input string tag);
        @(negedge clk);
        en = 1'b1; in_sym = x; cfg_load = 1'b0; cnt_clr = clr;
        #1 check({tag, ".match"}, 32'(match), 32'(exp_m));
        @(posedge clk);
        #1 check({tag, ".state"}, 32'(state), 32'(exp_s));
    endtask

    task automatic idle(input int cycles, input int exp_s, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; in_sym = 2'd1;
            #1 check({tag, ".match"}, 32'(match), 32'd0);
            @(posedge clk);
            #1 check({tag, ".state"}, 32'(state), 32'(exp_s));
        end
    endtask

    task automatic load(input logic [7:0] p, input logic e, input logic [1:0] x,
                        input logic clr, input string tag);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = p; en = e; in_sym = x; cnt_clr = clr;
        #1 check({tag, ".match"}, 32'(match), 32'd0);
        @(posedge clk);
        #1 check({tag, ".state"}, 32'(state), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_sym = '0; overlap = 1'b1;
        cfg_load = 1'b0; cfg_pattern = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", 32'(state), 32'd0);
        check("rst.cnt", 32'(match_cnt), 32'd0);
        check("rst.match", 32'(match), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Overlap on: P=2,1,2,1, border 2
        overlap = 1'b1;
        load(8'b01_10_01_10, 1'b0, 2'd0, 1'b1, "t1.load");
        send(2'd2, 1'b0, 1'b0, 1, "t1.s1");
        send(2'd1, 1'b0, 1'b0, 2, "t1.s2");
        send(2'd2, 1'b0, 1'b0, 3, "t1.s3");
        send(2'd1, 1'b0, 1'b1, 2, "t1.s4");
        send(2'd2, 1'b0, 1'b0, 3, "t1.s5");
        send(2'd1, 1'b0, 1'b1, 2, "t1.s6");
        idle(1, 2, "t1.idle");
        check("t1.cnt", 32'(match_cnt), 32'd2);

        // Overlap off
        overlap = 1'b0;
        load(8'b01_10_01_10, 1'b0, 2'd0, 1'b1, "t2.load");
        send(2'd2, 1'b0, 1'b0, 1, "t2.s1");
        send(2'd1, 1'b0, 1'b0, 2, "t2.s2");
        send(2'd2, 1'b0, 1'b0, 3, "t2.s3");
        send(2'd1, 1'b0, 1'b1, 0, "t2.s4");
        send(2'd2, 1'b0, 1'b0, 1, "t2.s5");
        send(2'd1, 1'b0, 1'b0, 2, "t2.s6");
        idle(1, 2, "t2.idle");
        check("t2.cnt", 32'(match_cnt), 32'd1);

        // Fallback: P=1,1,2,3
        overlap = 1'b1;
        load(8'b11_10_01_01, 1'b0, 2'd0, 1'b0, "t3.load");
        send(2'd1, 1'b0, 1'b0, 1, "t3.s1");
        send(2'd1, 1'b0, 1'b0, 2, "t3.s2");
        send(2'd1, 1'b0, 1'b0, 2, "t3.s3");
        send(2'd2, 1'b0, 1'b0, 3, "t3.s4");
        send(2'd3, 1'b0, 1'b1, 0, "t3.s5");
        send(2'd1, 1'b0, 1'b0, 1, "t3.s6");
        send(2'd1, 1'b0, 1'b0, 2, "t3.s7");
        send(2'd3, 1'b0, 1'b0, 0, "t3.s8");

        // Enable gaps, then a load that would otherwise complete the pattern
        load(8'b01_10_01_10, 1'b0, 2'd0, 1'b1, "t4.load");
        send(2'd2, 1'b0, 1'b0, 1, "t4.s1");
        idle(3, 1, "t4.gap1");
        send(2'd1, 1'b0, 1'b0, 2, "t4.s2");
        idle(3, 2, "t4.gap2");
        send(2'd2, 1'b0, 1'b0, 3, "t4.s3");
        load(8'b01_10_01_10, 1'b1, 2'd1, 1'b0, "t4.ldpri");
        idle(1, 0, "t4.after");
        check("t4.cnt", 32'(match_cnt), 32'd0);

        // Counter corners: 5 overlapping matches, small counter saturates at 3
        overlap = 1'b1;
        idle(1, 0, "t5.pre");
        send(2'd2, 1'b1, 1'b0, 1, "t5.a");
        send(2'd1, 1'b0, 1'b0, 2, "t5.b");
        send(2'd2, 1'b0, 1'b0, 3, "t5.c");
        send(2'd1, 1'b0, 1'b1, 2, "t5.m1");
        for (int m = 2; m <= 5; m++) begin
            send(2'd2, 1'b0, 1'b0, 3, "t5.x");
            send(2'd1, 1'b0, 1'b1, 2, "t5.m");
        end
        idle(1, 2, "t5.idle");
        check("t5.cnt_small_sat", 32'(match_cnt_s), 32'd3);
        check("t5.cnt_wide", 32'(match_cnt), 32'd5);
        send(2'd2, 1'b0, 1'b0, 3, "t5.y");
        send(2'd1, 1'b1, 1'b1, 2, "t5.clrm");
        idle(1, 2, "t5.idle2");
        check("t5.clr_match_small", 32'(match_cnt_s), 32'd1);
        check("t5.clr_match_wide", 32'(match_cnt), 32'd1);
        send(2'd0, 1'b1, 1'b0, 0, "t5.clr");
        idle(1, 0, "t5.idle3");
        check("t5.clr_plain", 32'(match_cnt), 32'd0);

        // Async reset mid-stream at state 3, off the clock edge
        send(2'd2, 1'b0, 1'b0, 1, "t6.s1");
        send(2'd1, 1'b0, 1'b0, 2, "t6.s2");
        send(2'd2, 1'b0, 1'b0, 3, "t6.s3");
        in_sym = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_state", 32'(state), 32'd0);
        check("t6.rst_cnt", 32'(match_cnt), 32'd0);
        check("t6.rst_match", 32'(match), 32'd0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        send(2'd0, 1'b0, 1'b0, 1, "t6.z1");
        send(2'd0, 1'b0, 1'b0, 2, "t6.z2");
        send(2'd0, 1'b0, 1'b0, 3, "t6.z3");
        send(2'd0, 1'b0, 1'b1, 3, "t6.z4");
        idle(1, 3, "t6.idle");
        check("t6.cnt", 32'(match_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
